mul32u_seq_arb: RTL and testbench

- Sequencer and two-port arbiter for the iterative unsigned shift-add multiplier datapath.
- Two requesters each present an operand pair through a valid/ready handshake.
- The block grants one requester at a time (round-robin) and runs the shift-add loop one partial product per clock.
- It returns the 2W-bit product on a shared response channel tagged with the requester id.
- Sits between the core's issue logic and the multiplier; replaces free-running, counter-driven operation with explicit start/busy/done control.

---
 rtl/mul32u_seq_arb.sv | 151 +++++++++++++++
 tb/tb_mul32u_seq_arb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mul32u_seq_arb.sv
// Round-robin two-port front end and sequencer for an iterative shift-add
// unsigned multiplier: one partial product per clock, tagged response.
module mul32u_seq_arb #(
  parameter int unsigned W          = 32,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [W-1:0]    req0_op1,
  input  logic [W-1:0]    req0_op2,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [W-1:0]    req1_op1,
  input  logic [W-1:0]    req1_op2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [2*W-1:0]  rsp_res,
  output logic            busy
);

  localparam int unsigned PW    = 2 * W;
  localparam int unsigned CNT_W = $clog2(W) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [W-1:0]     mplr_q, mplr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [PW-1:0]    rsp_res_q, rsp_res_d;
  logic             busy_q, busy_d;

  logic             gnt_id_c;
  logic             idle_c;
  logic [W-1:0]     sel_op1_c;
  logic [W-1:0]     sel_op2_c;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  always_comb begin
    gnt_id_c = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id_c = ~last_grant_q;
    end else if (req1_valid) begin
      gnt_id_c = 1'b1;
    end
    sel_op1_c = gnt_id_c ? req1_op1 : req0_op1;
    sel_op2_c = gnt_id_c ? req1_op2 : req0_op2;
  end

  // Ready is a pure decode of the grant, held low while reset is applied.
  assign idle_c     = (state_q == S_IDLE) && !rst;
  assign req0_ready = idle_c && req0_valid && !gnt_id_c;
  assign req1_ready = idle_c && req1_valid && gnt_id_c;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplr_d       = mplr_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_res_d    = rsp_res_q;

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          mcand_d      = {{W{1'b0}}, sel_op1_c};
          mplr_d       = sel_op2_c;
          acc_d        = '0;
          cnt_d        = '0;
          rsp_id_d     = gnt_id_c;
          last_grant_d = gnt_id_c;
          state_d      = S_RUN;
        end
      end

      S_RUN: begin
        if (mplr_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Finish on the last bit, or as soon as no set multiplier bits remain.
        if ((cnt_q == CNT_W'(W - 1)) || (EARLY_EXIT && (mplr_d == '0))) begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_res_d   = acc_d;
        end
      end

      S_DONE: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplr_q       <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_res_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplr_q       <= mplr_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_res_q    <= rsp_res_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul32u_seq_arb.sv
// Directed bench: two instances, index 0 runs all W steps, index 1 exits early.
module tb_mul32u_seq_arb;

  logic        clk;
  logic        rst;
  logic        v0  [2];
  logic        v1  [2];
  logic        rd0 [2];
  logic        rd1 [2];
  logic [31:0] a0  [2];
  logic [31:0] b0  [2];
  logic [31:0] a1  [2];
  logic [31:0] b1  [2];
  logic        rv  [2];
  logic        rr  [2];
  logic        rid [2];
  logic [63:0] res [2];
  logic        bsy [2];

  int total;
  int bad;

  mul32u_seq_arb #(.W(32), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst(rst),
    .req0_valid(v0[0]), .req0_ready(rd0[0]), .req0_op1(a0[0]), .req0_op2(b0[0]),
    .req1_valid(v1[0]), .req1_ready(rd1[0]), .req1_op1(a1[0]), .req1_op2(b1[0]),
    .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_id(rid[0]), .rsp_res(res[0]),
    .busy(bsy[0])
  );

  mul32u_seq_arb #(.W(32), .EARLY_EXIT(1'b1)) dut_early (
    .clk(clk), .rst(rst),
    .req0_valid(v0[1]), .req0_ready(rd0[1]), .req0_op1(a0[1]), .req0_op2(b0[1]),
    .req1_valid(v1[1]), .req1_ready(rd1[1]), .req1_op1(a1[1]), .req1_op2(b1[1]),
    .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_id(rid[1]), .rsp_res(res[1]),
    .busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Present a request and hold it until the handshake edge, then withdraw.
  task automatic issue(input int d, input bit id, input logic [31:0] op1, input logic [31:0] op2);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (id) begin v1[d] = 1'b1; a1[d] = op1; b1[d] = op2; end
    else    begin v0[d] = 1'b1; a0[d] = op1; b0[d] = op2; end
    for (int i = 0; i < 100; i++) begin
      #1;
      if (id ? rd1[d] : rd0[d]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("handshake", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    if (id) v1[d] = 1'b0; else v0[d] = 1'b0;
  endtask

  // Count edges after the handshake edge until the response shows up.
  task automatic wait_rsp(input int d, input string tag, input bit exp_id,
                          input logic [63:0] exp_res, input int exp_steps);
    int n;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (rv[d]) begin n = i; break; end
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_steps));
    chk({tag, "_res"}, res[d], exp_res);
    chk({tag, "_id"}, 64'(rid[d]), 64'(exp_id));
  endtask

  initial begin
    bit          both_rdy;
    bit          unstable;
    bit          early_rdy;
    int          nrsp;
    logic        ids  [4];
    logic [63:0] ress [4];

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int d = 0; d < 2; d++) begin
      v0[d] = 1'b0; v1[d] = 1'b0; rr[d] = 1'b1;
      a0[d] = '0; b0[d] = '0; a1[d] = '0; b1[d] = '0;
    end
    v0[0] = 1'b1;
    #12;
    chk("rst_valid", 64'(rv[0]), 64'd0);
    chk("rst_res", res[0], 64'd0);
    chk("rst_id", 64'(rid[0]), 64'd0);
    chk("rst_busy", 64'(bsy[0]), 64'd0);
    chk("rst_ready", 64'(rd0[0]), 64'd0);
    v0[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    issue(0, 1'b0, 32'd3, 32'd5);
    chk("run_busy", 64'(bsy[0]), 64'd1);
    wait_rsp(0, "full_3x5", 1'b0, 64'd15, 32);

    issue(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rsp(0, "full_max", 1'b1, 64'hFFFF_FFFE_0000_0001, 32);
    issue(1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rsp(1, "early_max", 1'b1, 64'hFFFF_FFFE_0000_0001, 32);

    issue(1, 1'b0, 32'd7, 32'd5);
    wait_rsp(1, "early_7x5", 1'b0, 64'd35, 3);
    issue(1, 1'b0, 32'd1234, 32'd0);
    wait_rsp(1, "early_zero", 1'b0, 64'd0, 1);
    issue(1, 1'b0, 32'd2, 32'h8000_0000);
    wait_rsp(1, "early_msb", 1'b0, 64'h1_0000_0000, 32);

    // Arbitration: both requesters stay valid; expect 0,1,0,1 from reset.
    do_reset();
    @(negedge clk);
    a0[1] = 32'd6; b0[1] = 32'd7; a1[1] = 32'd9; b1[1] = 32'd3;
    v0[1] = 1'b1; v1[1] = 1'b1;
    both_rdy = 1'b0;
    nrsp     = 0;
    for (int c = 0; c < 300 && nrsp < 4; c++) begin
      #1;
      if (rd0[1] && rd1[1]) both_rdy = 1'b1;
      if (rv[1]) begin
        ids[nrsp]  = rid[1];
        ress[nrsp] = res[1];
        nrsp++;
      end
      @(negedge clk);
    end
    v0[1] = 1'b0; v1[1] = 1'b0;
    chk("arb_count", 64'(nrsp), 64'd4);
    chk("arb_both_ready", 64'(both_rdy), 64'd0);
    for (int k = 0; k < nrsp; k++) begin
      chk($sformatf("arb_id%0d", k), 64'(ids[k]), 64'(k % 2));
      chk($sformatf("arb_res%0d", k), ress[k], (k % 2 == 0) ? 64'd42 : 64'd27);
    end

    // Backpressure: response held, no new grant while DONE.
    rr[1] = 1'b0;
    issue(1, 1'b0, 32'd7, 32'd5);
    wait_rsp(1, "bp", 1'b0, 64'd35, 3);
    a0[1] = 32'd4; b0[1] = 32'd3; v0[1] = 1'b1;
    unstable  = 1'b0;
    early_rdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (!rv[1] || res[1] !== 64'd35 || rid[1] !== 1'b0) unstable = 1'b1;
      if (rd0[1]) early_rdy = 1'b1;
    end
    chk("bp_stable", 64'(unstable), 64'd0);
    chk("bp_no_grant", 64'(early_rdy), 64'd0);
    rr[1] = 1'b1;
    #1;
    chk("bp_ready_in_done", 64'(rd0[1]), 64'd0);
    @(posedge clk);
    #1;
    chk("bp_valid_drop", 64'(rv[1]), 64'd0);
    chk("bp_ready_after", 64'(rd0[1]), 64'd1);
    @(posedge clk);
    #1;
    v0[1] = 1'b0;
    wait_rsp(1, "bp_next", 1'b0, 64'd12, 2);

    // Asynchronous reset between edges in the middle of a long operation.
    issue(0, 1'b0, 32'd100, 32'hFFFF_FFFF);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(bsy[0]), 64'd0);
    chk("arst_valid", 64'(rv[0]), 64'd0);
    chk("arst_res", res[0], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(0, 1'b1, 32'd11, 32'd13);
    wait_rsp(0, "arst_next", 1'b1, 64'd143, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
